// File: rtl/data_conv_pkg.sv
// Shared types and widths for the 8-bit to 16-bit word assembler.
package data_conv_pkg;

    localparam int BYTE_W    = 8;
    localparam int WORD_W    = 16;
    localparam int GAP_CNT_W = 16;

    typedef enum logic {
        IDLE,
        HALF
    } state_e;

endpackage

// File: rtl/data_8bit_to_16bit_if.sv
// Byte-in / word-out bus of the word assembler; master drives bytes and accepts words.
interface data_8bit_to_16bit_if;
    import data_conv_pkg::*;

    logic              i_en;
    logic [BYTE_W-1:0] i_data;
    logic              o_en;
    logic [WORD_W-1:0] o_data;
    logic              o_ready;
    logic              o_ovf;
    logic              o_timeout;

    modport master (
        output i_en, i_data, o_ready,
        input  o_en, o_data, o_ovf, o_timeout
    );

    modport slave (
        input  i_en, i_data, o_ready,
        output o_en, o_data, o_ovf, o_timeout
    );

endinterface

// File: rtl/data_8bit_to_16bit_gap_timer.sv
// Counts idle cycles while half a word is held; expire fires on the last allowed idle cycle.
module gap_timer
    import data_conv_pkg::*;
#(
    parameter logic [GAP_CNT_W-1:0] GAP_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam logic [GAP_CNT_W-1:0] LAST = GAP_CYCLES - 16'd1;

    logic [GAP_CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (run) begin
            count_d = count_q + 16'd1;
        end
    end

    // A zero limit disables expiry; the counter then just wraps harmlessly.
    assign expire = (GAP_CYCLES != '0) && run && (count_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/data_8bit_to_16bit.sv
// Packs pairs of byte strobes into 16-bit words with a one-entry output register.
// Optional statistics counters are enabled by defining DATA_8BIT_TO_16BIT_STAT_EN.
module data_8bit_to_16bit
    import data_conv_pkg::*;
#(
    parameter int                   MSB_FIRST  = 1,
    parameter logic [GAP_CNT_W-1:0] GAP_CYCLES = 16'd50000
) (
    input logic                 clk,
    input logic                 rst,
    data_8bit_to_16bit_if.slave bus
`ifdef DATA_8BIT_TO_16BIT_STAT_EN
    ,
    output logic [15:0]         o_word_cnt,
    output logic [7:0]          o_drop_cnt
`endif
);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic [WORD_W-1:0] data_q, data_d, word_new;
    logic              en_q, en_d;
    logic              ovf_q, ovf_d;
    logic              tmo_q, tmo_d;
    logic              capture, word_done, timer_clear, timer_run, expire, load;

    gap_timer #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_gap_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .run   (timer_run),
        .expire(expire)
    );

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.i_en) state_d = HALF;
            HALF:    if (bus.i_en || expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        capture     = 1'b0;
        word_done   = 1'b0;
        timer_clear = 1'b1;
        timer_run   = 1'b0;
        case (state_q)
            IDLE: capture = bus.i_en;
            HALF: begin
                word_done   = bus.i_en;
                timer_clear = bus.i_en;
                timer_run   = !bus.i_en;
            end
            default: ;
        endcase
    end

    assign word_new = (MSB_FIRST != 0) ? {byte_q, bus.i_data} : {bus.i_data, byte_q};

    // A completed word loads only if the slot is empty or drains this same cycle.
    assign load = word_done && (!en_q || bus.o_ready);

    always_comb begin
        byte_d = capture ? bus.i_data : byte_q;
        data_d = load ? word_new : data_q;
        en_d   = load || (en_q && !bus.o_ready);
        ovf_d  = word_done && en_q && !bus.o_ready;
        tmo_d  = expire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_q <= '0;
            data_q <= '0;
            en_q   <= 1'b0;
            ovf_q  <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            byte_q <= byte_d;
            data_q <= data_d;
            en_q   <= en_d;
            ovf_q  <= ovf_d;
            tmo_q  <= tmo_d;
        end
    end

    assign bus.o_en      = en_q;
    assign bus.o_data    = data_q;
    assign bus.o_ovf     = ovf_q;
    assign bus.o_timeout = tmo_q;

`ifdef DATA_8BIT_TO_16BIT_STAT_EN
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    always_comb begin
        word_cnt_d = word_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (en_q && bus.o_ready) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end
        if ((ovf_d || tmo_d) && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_word_cnt = word_cnt_q;
    assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_data_8bit_to_16bit.sv
// Self-checking bench: three configurations driven in lockstep against a transaction-level model.
module tb_data_8bit_to_16bit;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] data = 8'h00;
    logic       ready = 1'b0;

    always #5 clk = ~clk;

    data_8bit_to_16bit_if if_m ();
    data_8bit_to_16bit_if if_l ();
    data_8bit_to_16bit_if if_n ();

    assign if_m.i_en = en;  assign if_m.i_data = data;  assign if_m.o_ready = ready;
    assign if_l.i_en = en;  assign if_l.i_data = data;  assign if_l.o_ready = ready;
    assign if_n.i_en = en;  assign if_n.i_data = data;  assign if_n.o_ready = ready;

`ifdef DATA_8BIT_TO_16BIT_STAT_EN
    logic [15:0] wc_m, wc_l, wc_n;
    logic [7:0]  dc_m, dc_l, dc_n;
`endif

    data_8bit_to_16bit #(.MSB_FIRST(1), .GAP_CYCLES(16'd10)) dut_m (
        .clk(clk), .rst(rst), .bus(if_m)
`ifdef DATA_8BIT_TO_16BIT_STAT_EN
        , .o_word_cnt(wc_m), .o_drop_cnt(dc_m)
`endif
    );
    data_8bit_to_16bit #(.MSB_FIRST(0), .GAP_CYCLES(16'd10)) dut_l (
        .clk(clk), .rst(rst), .bus(if_l)
`ifdef DATA_8BIT_TO_16BIT_STAT_EN
        , .o_word_cnt(wc_l), .o_drop_cnt(dc_l)
`endif
    );
    data_8bit_to_16bit #(.MSB_FIRST(1), .GAP_CYCLES(16'd0)) dut_n (
        .clk(clk), .rst(rst), .bus(if_n)
`ifdef DATA_8BIT_TO_16BIT_STAT_EN
        , .o_word_cnt(wc_n), .o_drop_cnt(dc_n)
`endif
    );

    logic        d_en  [N];
    logic [15:0] d_dat [N];
    logic        d_ovf [N];
    logic        d_tmo [N];
    assign d_en[0] = if_m.o_en;  assign d_dat[0] = if_m.o_data;  assign d_ovf[0] = if_m.o_ovf;  assign d_tmo[0] = if_m.o_timeout;
    assign d_en[1] = if_l.o_en;  assign d_dat[1] = if_l.o_data;  assign d_ovf[1] = if_l.o_ovf;  assign d_tmo[1] = if_l.o_timeout;
    assign d_en[2] = if_n.o_en;  assign d_dat[2] = if_n.o_data;  assign d_ovf[2] = if_n.o_ovf;  assign d_tmo[2] = if_n.o_timeout;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: a pending-byte list, an idle-cycle count and a one-word slot per configuration.
    int          cfg_gap [N] = '{10, 10, 0};
    bit          cfg_msb [N] = '{1'b1, 1'b0, 1'b1};
    logic [7:0]  pend    [N][$];
    int          idle    [N];
    bit          m_oen   [N];
    logic [15:0] m_word  [N];
    bit          m_ovf   [N];
    bit          m_tmo   [N];

    task automatic model_step(input bit r, input bit e, input logic [7:0] d, input bit rdy);
        logic [7:0] first;
        for (int k = 0; k < N; k++) begin
            m_ovf[k] = 1'b0;
            m_tmo[k] = 1'b0;
            if (r) begin
                pend[k].delete();
                idle[k]   = 0;
                m_oen[k]  = 1'b0;
                m_word[k] = 16'h0000;
            end else begin
                if (m_oen[k] && rdy) m_oen[k] = 1'b0;
                if (e && pend[k].size() == 0) begin
                    pend[k].push_back(d);
                    idle[k] = 0;
                end else if (e) begin
                    first = pend[k].pop_front();
                    if (m_oen[k]) begin
                        m_ovf[k] = 1'b1;
                    end else begin
                        m_oen[k]  = 1'b1;
                        m_word[k] = cfg_msb[k] ? {first, d} : {d, first};
                    end
                end else if (pend[k].size() != 0) begin
                    idle[k]++;
                    if (cfg_gap[k] != 0 && idle[k] == cfg_gap[k]) begin
                        pend[k].delete();
                        m_tmo[k] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < N; k++) begin
            check($sformatf("dut%0d o_en", k),      32'(d_en[k]),  32'(m_oen[k]));
            check($sformatf("dut%0d o_data", k),    32'(d_dat[k]), 32'(m_word[k]));
            check($sformatf("dut%0d o_ovf", k),     32'(d_ovf[k]), 32'(m_ovf[k]));
            check($sformatf("dut%0d o_timeout", k), 32'(d_tmo[k]), 32'(m_tmo[k]));
        end
    endtask

    task automatic cycle(input bit r, input bit e, input logic [7:0] d, input bit rdy);
        rst = r; en = e; data = d; ready = rdy;
        @(posedge clk);
        model_step(r, e, d, rdy);
        #1;
        compare_all();
    endtask

    typedef struct {
        bit          r;
        bit          e;
        logic [7:0]  d;
        bit          rdy;
        bit          x_en;
        logic [15:0] x_dm;
        logic [15:0] x_dl;
        bit          x_ovf;
        bit          x_tmo;
    } vec_t;

    vec_t vecs [23];

    initial begin
        // reset (i_en ignored), MSB/LSB placement
        vecs[0]  = '{1, 1, 8'hFF, 1, 0, 16'h0000, 16'h0000, 0, 0};
        vecs[1]  = '{0, 1, 8'hA5, 1, 0, 16'h0000, 16'h0000, 0, 0};
        vecs[2]  = '{0, 1, 8'h3C, 1, 1, 16'hA53C, 16'h3CA5, 0, 0};
        vecs[3]  = '{0, 0, 8'h00, 1, 0, 16'hA53C, 16'h3CA5, 0, 0};
        // accept and reload on the same edge keeps o_en high
        vecs[4]  = '{0, 1, 8'h12, 1, 0, 16'hA53C, 16'h3CA5, 0, 0};
        vecs[5]  = '{0, 1, 8'h34, 0, 1, 16'h1234, 16'h3412, 0, 0};
        vecs[6]  = '{0, 1, 8'h56, 0, 1, 16'h1234, 16'h3412, 0, 0};
        vecs[7]  = '{0, 1, 8'h78, 1, 1, 16'h5678, 16'h7856, 0, 0};
        vecs[8]  = '{0, 1, 8'h9A, 0, 1, 16'h5678, 16'h7856, 0, 0};
        vecs[9]  = '{0, 1, 8'hBC, 1, 1, 16'h9ABC, 16'hBC9A, 0, 0};
        vecs[10] = '{0, 0, 8'h00, 1, 0, 16'h9ABC, 16'hBC9A, 0, 0};
        // overflow with o_ready low
        vecs[11] = '{0, 1, 8'h12, 0, 0, 16'h9ABC, 16'hBC9A, 0, 0};
        vecs[12] = '{0, 1, 8'h34, 0, 1, 16'h1234, 16'h3412, 0, 0};
        vecs[13] = '{0, 1, 8'h56, 0, 1, 16'h1234, 16'h3412, 0, 0};
        vecs[14] = '{0, 1, 8'h78, 0, 1, 16'h1234, 16'h3412, 1, 0};
        vecs[15] = '{0, 0, 8'h00, 0, 1, 16'h1234, 16'h3412, 0, 0};
        vecs[16] = '{0, 0, 8'h00, 1, 0, 16'h1234, 16'h3412, 0, 0};
        vecs[17] = '{0, 0, 8'h00, 1, 0, 16'h1234, 16'h3412, 0, 0};
        // reset in HALF discards the byte silently
        vecs[18] = '{0, 1, 8'hFF, 1, 0, 16'h1234, 16'h3412, 0, 0};
        vecs[19] = '{1, 0, 8'h00, 1, 0, 16'h0000, 16'h0000, 0, 0};
        vecs[20] = '{0, 1, 8'h01, 1, 0, 16'h0000, 16'h0000, 0, 0};
        vecs[21] = '{0, 1, 8'h02, 1, 1, 16'h0102, 16'h0201, 0, 0};
        vecs[22] = '{0, 0, 8'h00, 1, 0, 16'h0102, 16'h0201, 0, 0};

        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        check("reset o_en",      32'(if_m.o_en),      32'd0);
        check("reset o_data",    32'(if_m.o_data),    32'h0000);
        check("reset o_ovf",     32'(if_m.o_ovf),     32'd0);
        check("reset o_timeout", 32'(if_m.o_timeout), 32'd0);

        for (int i = 0; i < 23; i++) begin
            cycle(vecs[i].r, vecs[i].e, vecs[i].d, vecs[i].rdy);
            check($sformatf("vec%0d o_en", i),      32'(if_m.o_en),      32'(vecs[i].x_en));
            check($sformatf("vec%0d o_data", i),    32'(if_m.o_data),    32'(vecs[i].x_dm));
            check($sformatf("vec%0d lsb o_data", i), 32'(if_l.o_data),   32'(vecs[i].x_dl));
            check($sformatf("vec%0d o_ovf", i),     32'(if_m.o_ovf),     32'(vecs[i].x_ovf));
            check($sformatf("vec%0d o_timeout", i), 32'(if_m.o_timeout), 32'(vecs[i].x_tmo));
        end

        // gap timeout after ten idle cycles, then back in IDLE
        cycle(1'b0, 1'b1, 8'h11, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            check($sformatf("gap idle%0d o_timeout", i), 32'(if_m.o_timeout), 32'(i == 10));
        end
        check("gap disabled o_timeout", 32'(if_n.o_timeout), 32'd0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check("gap pulse width", 32'(if_m.o_timeout), 32'd0);
        cycle(1'b0, 1'b1, 8'h22, 1'b1);
        cycle(1'b0, 1'b1, 8'h33, 1'b1);
        check("after timeout o_en",   32'(if_m.o_en),   32'd1);
        check("after timeout o_data", 32'(if_m.o_data), 32'h2233);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);

        // second byte on the expiry cycle wins over the timeout
        cycle(1'b0, 1'b1, 8'h44, 1'b1);
        for (int i = 1; i <= 9; i++) cycle(1'b0, 1'b0, 8'h00, 1'b1);
        cycle(1'b0, 1'b1, 8'h55, 1'b1);
        check("race o_timeout", 32'(if_m.o_timeout), 32'd0);
        check("race o_en",      32'(if_m.o_en),      32'd1);
        check("race o_data",    32'(if_m.o_data),    32'h4455);

        // random traffic with idle bursts and occasional reset
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 4),
                  8'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
